rsa_modexp_sequencer: RTL and testbench

//   Handshake-driven controller for Montgomery modular exponentiation (X = M^E mod N), left-to-right square-and-multiply.

---
 rtl/rsa_modexp_sequencer_if.sv | 31 +++
 rtl/rsa_modexp_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_rsa_modexp_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_sequencer_if.sv
// Handshake and operand-control bundle between the modexp sequencer and its host/MMM datapath.
// The master side issues start/abort/exponent and returns mmm_done; the slave side is the sequencer.
interface rsa_modexp_sequencer_if #(
  parameter int EXP_WIDTH = 8,
  parameter int IDX_W     = $clog2(EXP_WIDTH + 1),
  parameter int OPCNT_W   = $clog2(2 * EXP_WIDTH + 4)
);
  logic                 start;
  logic                 abort;
  logic [EXP_WIDTH-1:0] exp_e;
  logic                 mmm_done;
  logic                 mmm_start;
  logic [1:0]           opa_sel;
  logic [1:0]           opb_sel;
  logic                 ld_abar;
  logic                 ld_x;
  logic                 busy;
  logic                 done;
  logic [IDX_W-1:0]     bits_left;
  logic [OPCNT_W-1:0]   op_count;

  modport master (
    output start, abort, exp_e, mmm_done,
    input  mmm_start, opa_sel, opb_sel, ld_abar, ld_x, busy, done, bits_left, op_count
  );

  modport slave (
    input  start, abort, exp_e, mmm_done,
    output mmm_start, opa_sel, opb_sel, ld_abar, ld_x, busy, done, bits_left, op_count
  );
endinterface

// File: rtl/rsa_modexp_sequencer.sv
// Left-to-right square-and-multiply controller for Montgomery modexp (X = M^E mod N).
// Drives MMM operand selects, launches each op and waits on mmm_done before loading the result.
//
// state   | meaning
// IDLE    | waiting for start
// MAP_M   | Abar = MMM(M, R2)
// MAP_X   | X = MMM(ONE, R2)
// SCAN    | skip leading zero exponent bits
// SQR     | X = MMM(X, X)
// MUL     | X = MMM(X, Abar), dummy on 0 bits in constant-time mode
// NEXT    | advance to next exponent bit
// REMAP   | X = MMM(X, ONE), leave Montgomery domain
// DONE    | result valid in X
module rsa_modexp_sequencer #(
  parameter int EXP_WIDTH  = 8,
  parameter int SKIP_LZ    = 1,
  parameter int CONST_TIME = 0,
  parameter int IDX_W      = $clog2(EXP_WIDTH + 1),
  parameter int OPCNT_W    = $clog2(2 * EXP_WIDTH + 4)
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    ena,
  rsa_modexp_sequencer_if.slave   bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_MAP_M, S_MAP_X, S_SCAN, S_SQR, S_MUL, S_NEXT, S_REMAP, S_DONE
  } state_t;

  // Constant-time operation must not leak the exponent length, so it never skips.
  localparam bit CT       = (CONST_TIME != 0);
  localparam bit SKIP_EFF = (SKIP_LZ != 0) && !CT;

  state_t               state_q, state_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [IDX_W-1:0]     bits_q, bits_d;
  logic [OPCNT_W-1:0]   opcnt_q, opcnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 issued_q, issued_d;

  logic                 start_c, ldx_c, ldabar_c;
  logic [1:0]           opa_c, opb_c;
  logic                 is_op, op_fin, msb;
  logic [EXP_WIDTH-1:0] exp_shl;

  assign msb     = exp_q[EXP_WIDTH-1];
  assign exp_shl = {exp_q[EXP_WIDTH-2:0], 1'b0};
  assign is_op   = (state_q == S_MAP_M) || (state_q == S_MAP_X) || (state_q == S_SQR) ||
                   (state_q == S_MUL)   || (state_q == S_REMAP);
  assign op_fin  = is_op && issued_q && bus.mmm_done;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q  <= S_IDLE;
      exp_q    <= '0;
      bits_q   <= '0;
      opcnt_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      issued_q <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      bits_q   <= bits_d;
      opcnt_q  <= opcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      issued_q <= issued_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    bits_d   = bits_q;
    opcnt_d  = opcnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    issued_d = issued_q;
    start_c  = 1'b0;
    ldx_c    = 1'b0;
    ldabar_c = 1'b0;
    if (ena) begin
      if (bus.abort) begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        issued_d = 1'b0;
      end else begin
        // Every op state launches once on entry, then waits for the MMM.
        if (is_op && !issued_q) begin
          start_c  = 1'b1;
          issued_d = 1'b1;
          opcnt_d  = opcnt_q + OPCNT_W'(1);
        end
        if (op_fin) issued_d = 1'b0;
        case (state_q)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              exp_d   = bus.exp_e;
              bits_d  = IDX_W'(EXP_WIDTH);
              opcnt_d = '0;
              done_d  = 1'b0;
              busy_d  = 1'b1;
              state_d = S_MAP_M;
            end
          end
          S_MAP_M: begin
            if (op_fin) begin
              ldabar_c = 1'b1;
              state_d  = S_MAP_X;
            end
          end
          S_MAP_X: begin
            if (op_fin) begin
              ldx_c   = 1'b1;
              state_d = S_SCAN;
            end
          end
          S_SCAN: begin
            if (!SKIP_EFF || msb) begin
              state_d = S_SQR;
            end else if (bits_q == '0) begin
              state_d = S_REMAP;
            end else begin
              exp_d  = exp_shl;
              bits_d = bits_q - IDX_W'(1);
              if (bits_q == IDX_W'(1)) state_d = S_REMAP;
            end
          end
          S_SQR: begin
            if (op_fin) begin
              ldx_c   = 1'b1;
              state_d = (msb || CT) ? S_MUL : S_NEXT;
            end
          end
          S_MUL: begin
            if (op_fin) begin
              ldx_c   = msb;
              state_d = S_NEXT;
            end
          end
          S_NEXT: begin
            exp_d   = exp_shl;
            bits_d  = bits_q - IDX_W'(1);
            state_d = (bits_q == IDX_W'(1)) ? S_REMAP : S_SQR;
          end
          S_REMAP: begin
            if (op_fin) begin
              ldx_c   = 1'b1;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    opa_c = 2'b00;
    opb_c = 2'b00;
    case (state_q)
      S_MAP_M: begin opa_c = 2'b01; opb_c = 2'b10; end
      S_MAP_X: begin opa_c = 2'b10; opb_c = 2'b10; end
      S_SQR:   begin opa_c = 2'b00; opb_c = 2'b00; end
      S_MUL:   begin opa_c = 2'b00; opb_c = 2'b01; end
      S_REMAP: begin opa_c = 2'b00; opb_c = 2'b11; end
      default: begin opa_c = 2'b00; opb_c = 2'b00; end
    endcase
  end

  assign bus.mmm_start = start_c;
  assign bus.ld_x      = ldx_c;
  assign bus.ld_abar   = ldabar_c;
  assign bus.opa_sel   = opa_c;
  assign bus.opb_sel   = opb_c;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bits_left = bits_q;
  assign bus.op_count  = opcnt_q;

endmodule

// File: tb/tb_rsa_modexp_sequencer.sv
// Directed bench for rsa_modexp_sequencer: three configurations behind one selectable stimulus port,
// with a 3-cycle-latency MMM responder folded into the per-cycle step task.
module tb_rsa_modexp_sequencer;

  logic       clk;
  logic       rstb;
  logic       ena;
  logic       start;
  logic       abort;
  logic [7:0] exp_e;
  logic       mmm_done;
  logic [1:0] sel;

  rsa_modexp_sequencer_if #(.EXP_WIDTH(8)) if_skip ();
  rsa_modexp_sequencer_if #(.EXP_WIDTH(8)) if_full ();
  rsa_modexp_sequencer_if #(.EXP_WIDTH(8)) if_ct ();

  rsa_modexp_sequencer #(.EXP_WIDTH(8), .SKIP_LZ(1), .CONST_TIME(0)) u_skip (
    .clk(clk), .rstb(rstb), .ena(ena), .bus(if_skip));
  rsa_modexp_sequencer #(.EXP_WIDTH(8), .SKIP_LZ(0), .CONST_TIME(0)) u_full (
    .clk(clk), .rstb(rstb), .ena(ena), .bus(if_full));
  rsa_modexp_sequencer #(.EXP_WIDTH(8), .SKIP_LZ(1), .CONST_TIME(1)) u_ct (
    .clk(clk), .rstb(rstb), .ena(ena), .bus(if_ct));

  assign if_skip.start    = start & (sel == 2'd0);
  assign if_skip.abort    = abort & (sel == 2'd0);
  assign if_skip.mmm_done = mmm_done & (sel == 2'd0);
  assign if_skip.exp_e    = exp_e;
  assign if_full.start    = start & (sel == 2'd1);
  assign if_full.abort    = abort & (sel == 2'd1);
  assign if_full.mmm_done = mmm_done & (sel == 2'd1);
  assign if_full.exp_e    = exp_e;
  assign if_ct.start      = start & (sel == 2'd2);
  assign if_ct.abort      = abort & (sel == 2'd2);
  assign if_ct.mmm_done   = mmm_done & (sel == 2'd2);
  assign if_ct.exp_e      = exp_e;

  logic       m_start, m_ldx, m_ldabar, m_busy, m_done;
  logic [1:0] m_opa, m_opb;
  logic [3:0] m_bits;
  logic [4:0] m_opcnt;

  always_comb begin
    m_start = if_skip.mmm_start; m_ldx = if_skip.ld_x; m_ldabar = if_skip.ld_abar;
    m_busy = if_skip.busy; m_done = if_skip.done; m_opa = if_skip.opa_sel;
    m_opb = if_skip.opb_sel; m_bits = if_skip.bits_left; m_opcnt = if_skip.op_count;
    if (sel == 2'd1) begin
      m_start = if_full.mmm_start; m_ldx = if_full.ld_x; m_ldabar = if_full.ld_abar;
      m_busy = if_full.busy; m_done = if_full.done; m_opa = if_full.opa_sel;
      m_opb = if_full.opb_sel; m_bits = if_full.bits_left; m_opcnt = if_full.op_count;
    end else if (sel == 2'd2) begin
      m_start = if_ct.mmm_start; m_ldx = if_ct.ld_x; m_ldabar = if_ct.ld_abar;
      m_busy = if_ct.busy; m_done = if_ct.done; m_opa = if_ct.opa_sel;
      m_opb = if_ct.opb_sel; m_bits = if_ct.bits_left; m_opcnt = if_ct.op_count;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ops, n_ldx, n_ldabar, cyc, pending, last_ld, gap;
  int abort_ldx, cyc_a, ok;
  logic abort_arm, abort_hit, any_start;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock: MMM responder pulses mmm_done 3 cycles after each launch, then outputs are sampled.
  task automatic step();
    @(negedge clk);
    mmm_done = 1'b0;
    abort    = 1'b0;
    if (ena && pending > 0) begin
      pending--;
      if (pending == 0) mmm_done = 1'b1;
    end
    if (abort_arm && mmm_done) begin
      abort     = 1'b1;
      abort_arm = 1'b0;
      abort_hit = 1'b1;
    end
    #1;
    cyc++;
    if (abort) abort_ldx = int'(m_ldx);
    if (m_start) begin
      ops++;
      pending = 3;
      if (ops == 3) gap = cyc - last_ld;
    end
    if (m_ldx) begin
      n_ldx++;
      last_ld = cyc;
    end
    if (m_ldabar) n_ldabar++;
  endtask

  task automatic kick(input logic [7:0] e);
    ops = 0; n_ldx = 0; n_ldabar = 0; cyc = 0; pending = 0; last_ld = 0; gap = 0;
    step();
    start = 1'b1;
    exp_e = e;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (m_done && !m_busy) begin
        ok = 1;
        break;
      end
    end
    check_eq(tag, ok, 1);
  endtask

  task automatic step_until_ops(input string tag, input int n);
    for (int i = 0; i < 100; i++) begin
      if (ops >= n) break;
      step();
    end
    check_eq(tag, int'(ops >= n), 1);
  endtask

  initial begin
    rstb = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; exp_e = '0; mmm_done = 1'b0;
    sel = 2'd0; pending = 0; abort_arm = 1'b0; abort_hit = 1'b0; abort_ldx = 0;
    repeat (3) step();
    check_eq("rst_busy", int'(m_busy), 0);
    check_eq("rst_done", int'(m_done), 0);
    check_eq("rst_opcnt", int'(m_opcnt), 0);
    check_eq("rst_bits", int'(m_bits), 0);
    check_eq("rst_sel", int'({m_opa, m_opb}), 0);
    rstb = 1'b1;
    step();

    // Skip-leading-zero, exp = 0000_0101
    sel = 2'd0;
    kick(8'h05);
    check_eq("skip05_map_m_sel", int'({m_opa, m_opb}), 4'b0110);
    run_to_done("skip05_finish");
    check_eq("skip05_opcnt", int'(m_opcnt), 8);
    check_eq("skip05_ops", ops, 8);
    check_eq("skip05_ldx", n_ldx, 7);
    check_eq("skip05_ldabar", n_ldabar, 1);
    check_eq("skip05_bits", int'(m_bits), 0);
    repeat (3) step();
    check_eq("skip05_done_hold", int'(m_done), 1);

    // Zero exponent: only MAP_M, MAP_X, REMAP; SCAN spans 8 cycles
    kick(8'h00);
    run_to_done("skip00_finish");
    check_eq("skip00_opcnt", int'(m_opcnt), 3);
    check_eq("skip00_ldx", n_ldx, 2);
    check_eq("skip00_scan_gap", gap, 9);

    // Full scan, exp = 0000_0101
    sel = 2'd1;
    kick(8'h05);
    run_to_done("full05_finish");
    check_eq("full05_opcnt", int'(m_opcnt), 13);
    check_eq("full05_ldx", n_ldx, 12);
    check_eq("full05_busy", int'(m_busy), 0);

    // Constant time: timing independent of exponent value
    sel = 2'd2;
    kick(8'h05);
    run_to_done("ct05_finish");
    check_eq("ct05_opcnt", int'(m_opcnt), 19);
    check_eq("ct05_ldx", n_ldx, 12);
    cyc_a = cyc;
    kick(8'hFF);
    run_to_done("ctff_finish");
    check_eq("ctff_opcnt", int'(m_opcnt), 19);
    check_eq("ctff_ldx", n_ldx, 18);
    check_eq("ct_cycles_equal", cyc, cyc_a);

    // Abort coincident with mmm_done of the first SQR
    sel = 2'd0;
    kick(8'h05);
    step_until_ops("abort_reach_sqr", 3);
    check_eq("abort_sqr_sel", int'({m_opa, m_opb}), 0);
    abort_arm = 1'b1;
    abort_hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (abort_hit) break;
      step();
    end
    check_eq("abort_hit", int'(abort_hit), 1);
    check_eq("abort_no_ldx", abort_ldx, 0);
    step();
    check_eq("abort_busy", int'(m_busy), 0);
    check_eq("abort_done", int'(m_done), 0);
    repeat (3) step();
    check_eq("abort_no_relaunch", ops, 3);
    kick(8'h05);
    run_to_done("post_abort_finish");
    check_eq("post_abort_opcnt", int'(m_opcnt), 8);
    check_eq("post_abort_ldx", n_ldx, 7);

    // Freeze mid-MUL with ena=0, then reset mid-SQR
    kick(8'h05);
    step_until_ops("ena_reach_mul", 4);
    step();
    ena = 1'b0;
    any_start = 1'b0;
    repeat (5) begin
      step();
      any_start = any_start | m_start;
    end
    check_eq("ena_no_start", int'(any_start), 0);
    check_eq("ena_opcnt_hold", int'(m_opcnt), 4);
    check_eq("ena_busy_hold", int'(m_busy), 1);
    check_eq("ena_mul_sel_hold", int'({m_opa, m_opb}), 4'b0001);
    ena = 1'b1;
    step_until_ops("ena_reach_sqr", 5);
    check_eq("ena_next_is_sqr", int'({m_opa, m_opb}), 0);
    step();
    rstb = 1'b0;
    step();
    check_eq("rst2_busy", int'(m_busy), 0);
    check_eq("rst2_done", int'(m_done), 0);
    check_eq("rst2_opcnt", int'(m_opcnt), 0);
    check_eq("rst2_bits", int'(m_bits), 0);
    check_eq("rst2_outs", int'({m_start, m_ldx, m_ldabar, m_opa, m_opb}), 0);
    rstb = 1'b1;
    pending = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
